// File: rtl/mips32_pipeline.sv
// Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB) over one unified word memory.
// Operands are forwarded into EX; branches resolve in EX and squash the two younger slots.
module mips32_pipeline #(
    parameter int MEM_DEPTH = 1024,
    parameter int NREGS     = 32
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    logic [31:0] Reg [0:NREGS-1];
    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic        ifid_valid_q;
    logic [31:0] ifid_ir_q;
    logic [31:0] ifid_npc_q;

    logic        idex_valid_q;
    logic [5:0]  idex_op_q;
    logic [4:0]  idex_rs_q;
    logic [4:0]  idex_rt_q;
    logic [4:0]  idex_dst_q;
    logic [31:0] idex_npc_q;
    logic [31:0] idex_a_q;
    logic [31:0] idex_b_q;
    logic [31:0] idex_imm_q;

    logic        exmem_valid_q;
    logic [5:0]  exmem_op_q;
    logic [4:0]  exmem_dst_q;
    logic [31:0] exmem_alu_q;
    logic [31:0] exmem_b_q;

    logic        memwb_valid_q;
    logic [5:0]  memwb_op_q;
    logic [4:0]  memwb_dst_q;
    logic [31:0] memwb_alu_q;
    logic [31:0] memwb_lmd_q;

    logic [31:0] if_ir_s;
    logic [31:0] pc_d;
    logic [4:0]  id_rs_s;
    logic [4:0]  id_rt_s;
    logic [31:0] id_a_s;
    logic [31:0] id_b_s;
    logic [31:0] wb_data_s;
    logic        wb_fwd_s;
    logic        wb_we_s;
    logic        hlt_in_wb_s;
    logic        stall_s;
    logic        exmem_fwd_s;
    logic        older_hlt_s;
    logic [31:0] ex_a_s;
    logic [31:0] ex_b_s;
    logic [31:0] ex_opb_s;
    logic [31:0] ex_alu_s;
    logic        ex_taken_s;
    logic [AW-1:0] mem_addr_s;
    logic [31:0] mem_rdata_s;
    logic        mem_we_s;

    function automatic logic is_rr(input logic [5:0] op);
        return (op <= OP_MUL);
    endfunction

    function automatic logic is_alu(input logic [5:0] op);
        return is_rr(op) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI);
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        return is_alu(op) || (op == OP_LW);
    endfunction

    function automatic logic [4:0] dest_of(input logic [31:0] ir);
        if (is_rr(ir[31:26])) begin
            return ir[15:11];
        end else begin
            return ir[20:16];
        end
    endfunction

    assign halted = HALTED;

    // Fetch word, writeback selection, halt freeze and register read with same-cycle WB bypass.
    always_comb begin
        if_ir_s     = Mem[PC[AW-1:0]];
        wb_data_s   = (memwb_op_q == OP_LW) ? memwb_lmd_q : memwb_alu_q;
        wb_fwd_s    = memwb_valid_q && writes_reg(memwb_op_q) && (memwb_dst_q != 5'd0);
        hlt_in_wb_s = memwb_valid_q && (memwb_op_q == OP_HLT);
        stall_s     = HALTED || hlt_in_wb_s;
        wb_we_s     = wb_fwd_s && !stall_s && !rst;
        id_rs_s     = ifid_ir_q[25:21];
        id_rt_s     = ifid_ir_q[20:16];
        if (id_rs_s == 5'd0) begin
            id_a_s = 32'd0;
        end else if (wb_we_s && (memwb_dst_q == id_rs_s)) begin
            id_a_s = wb_data_s;
        end else begin
            id_a_s = Reg[id_rs_s];
        end
        if (id_rt_s == 5'd0) begin
            id_b_s = 32'd0;
        end else if (wb_we_s && (memwb_dst_q == id_rt_s)) begin
            id_b_s = wb_data_s;
        end else begin
            id_b_s = Reg[id_rt_s];
        end
    end

    // EX operand forwarding, youngest producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        exmem_fwd_s = exmem_valid_q && is_alu(exmem_op_q) && (exmem_dst_q != 5'd0);
        if (exmem_fwd_s && (exmem_dst_q == idex_rs_q)) begin
            ex_a_s = exmem_alu_q;
        end else if (wb_fwd_s && (memwb_dst_q == idex_rs_q)) begin
            ex_a_s = wb_data_s;
        end else begin
            ex_a_s = idex_a_q;
        end
        if (exmem_fwd_s && (exmem_dst_q == idex_rt_q)) begin
            ex_b_s = exmem_alu_q;
        end else if (wb_fwd_s && (memwb_dst_q == idex_rt_q)) begin
            ex_b_s = wb_data_s;
        end else begin
            ex_b_s = idex_b_q;
        end
    end

    // ALU, effective address, branch target and branch decision.
    always_comb begin
        ex_opb_s = is_rr(idex_op_q) ? ex_b_s : idex_imm_q;
        case (idex_op_q)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_alu_s = ex_a_s + ex_opb_s;
            OP_SUB, OP_SUBI:               ex_alu_s = ex_a_s - ex_opb_s;
            OP_AND:                        ex_alu_s = ex_a_s & ex_opb_s;
            OP_OR:                         ex_alu_s = ex_a_s | ex_opb_s;
            OP_SLT, OP_SLTI:               ex_alu_s = {31'd0, ($signed(ex_a_s) < $signed(ex_opb_s))};
            OP_MUL:                        ex_alu_s = ex_a_s * ex_opb_s;
            OP_BNEQZ, OP_BEQZ:             ex_alu_s = idex_npc_q + idex_imm_q;
            default:                       ex_alu_s = 32'd0;
        endcase
        // A branch younger than an in-flight HLT must not redirect the PC.
        older_hlt_s = (exmem_valid_q && (exmem_op_q == OP_HLT)) || hlt_in_wb_s;
        ex_taken_s  = idex_valid_q && !older_hlt_s &&
                      (((idex_op_q == OP_BNEQZ) && (ex_a_s != 32'd0)) ||
                       ((idex_op_q == OP_BEQZ) && (ex_a_s == 32'd0)));
        pc_d        = ex_taken_s ? ex_alu_s : (PC + 32'd1);
    end

    // Data memory port; the store of an instruction behind a halting HLT is dropped.
    always_comb begin
        mem_addr_s  = exmem_alu_q[AW-1:0];
        mem_rdata_s = Mem[mem_addr_s];
        mem_we_s    = exmem_valid_q && (exmem_op_q == OP_SW) && !stall_s && !rst;
    end

    // Pipeline advance: reset flushes to bubbles, halt freezes, a taken branch squashes IF and ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC            <= 32'd0;
            HALTED        <= 1'b0;
            TAKEN_BRANCH  <= 1'b0;
            ifid_valid_q  <= 1'b0;
            idex_valid_q  <= 1'b0;
            exmem_valid_q <= 1'b0;
            memwb_valid_q <= 1'b0;
        end else if (stall_s) begin
            HALTED        <= 1'b1;
            TAKEN_BRANCH  <= 1'b0;
        end else begin
            PC            <= pc_d;
            TAKEN_BRANCH  <= ex_taken_s;
            ifid_valid_q  <= !ex_taken_s;
            ifid_ir_q     <= if_ir_s;
            ifid_npc_q    <= PC + 32'd1;
            idex_valid_q  <= ifid_valid_q && !ex_taken_s;
            idex_op_q     <= ifid_ir_q[31:26];
            idex_rs_q     <= id_rs_s;
            idex_rt_q     <= id_rt_s;
            idex_dst_q    <= dest_of(ifid_ir_q);
            idex_npc_q    <= ifid_npc_q;
            idex_a_q      <= id_a_s;
            idex_b_q      <= id_b_s;
            idex_imm_q    <= {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};
            exmem_valid_q <= idex_valid_q;
            exmem_op_q    <= idex_op_q;
            exmem_dst_q   <= idex_dst_q;
            exmem_alu_q   <= ex_alu_s;
            exmem_b_q     <= ex_b_s;
            memwb_valid_q <= exmem_valid_q;
            memwb_op_q    <= exmem_op_q;
            memwb_dst_q   <= exmem_dst_q;
            memwb_alu_q   <= exmem_alu_q;
            memwb_lmd_q   <= mem_rdata_s;
        end
    end

    // Register file write port (no reset so preloaded contents survive).
    always_ff @(posedge clk) begin
        if (wb_we_s) begin
            Reg[memwb_dst_q] <= wb_data_s;
        end
    end

    // Unified memory store port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            Mem[mem_addr_s] <= exmem_b_q;
        end
    end
endmodule

// File: tb/tb_mips32_pipeline.sv
// Bench for mips32_pipeline: directed programs and random forward-branching programs,
// final architectural state compared against a sequential instruction-level interpreter.
module tb_mips32_pipeline;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [31:0] HLT_W   = 32'hfc000000;
    localparam logic [31:0] NOP_W   = 32'h40000000;

    localparam logic [31:0] FACT [0:10] = '{
        32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
        32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
        32'hfc000000};
    localparam logic [31:0] R2_SEQ [0:6] = '{
        32'd1, 32'd7, 32'd42, 32'd210, 32'd840, 32'd2520, 32'd5040};

    logic clk;
    logic rst;
    logic halted;
    int   checks;
    int   failures;
    int   run_cycles;
    int   taken_cycles;
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:1023];
    logic [31:0] r2_hist [$];

    mips32_pipeline dut (.clk(clk), .rst(rst), .halted(halted));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input int a, input logic [31:0] w);
        dut.Mem[a] = w;
        m_mem[a]   = w;
    endtask

    task automatic init_state(input bit rnd);
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = rnd ? $urandom : 32'd0;
            put(i, w);
        end
        for (int i = 0; i < 32; i++) begin
            w = rnd ? $urandom : 32'(i);
            dut.Reg[i] = w;
            m_reg[i]   = w;
        end
    endtask

    task automatic m_wr(input logic [4:0] d, input logic [31:0] v);
        if (d != 5'd0) m_reg[d] = v;
    endtask

    // Sequential instruction-set interpreter: one instruction at a time, no pipeline.
    task automatic model_run();
        logic [31:0] pc, ir, a, b, imm;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        pc = 32'd0;
        for (int step = 0; step < 4096; step++) begin
            ir  = m_mem[pc[9:0]];
            op  = ir[31:26];
            rs  = ir[25:21];
            rt  = ir[20:16];
            rd  = ir[15:11];
            imm = {{16{ir[15]}}, ir[15:0]};
            a   = (rs == 5'd0) ? 32'd0 : m_reg[rs];
            b   = (rt == 5'd0) ? 32'd0 : m_reg[rt];
            pc  = pc + 32'd1;
            if (op == 6'b111111) break;
            case (op)
                6'd0:    m_wr(rd, a + b);
                6'd1:    m_wr(rd, a - b);
                6'd2:    m_wr(rd, a & b);
                6'd3:    m_wr(rd, a | b);
                6'd4:    m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'd5:    m_wr(rd, a * b);
                6'd8:    m_wr(rt, m_mem[10'(a + imm)]);
                6'd9:    m_mem[10'(a + imm)] = b;
                6'd10:   m_wr(rt, a + imm);
                6'd11:   m_wr(rt, a - imm);
                6'd12:   m_wr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
                6'd13:   if (a != 32'd0) pc = pc + imm;
                6'd14:   if (a == 32'd0) pc = pc + imm;
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        logic [31:0] last_r2;
        run_cycles   = 0;
        taken_cycles = 0;
        r2_hist.delete();
        last_r2 = dut.Reg[2];
        while (halted !== 1'b1 && run_cycles < budget) begin
            @(negedge clk);
            run_cycles++;
            if (dut.TAKEN_BRANCH === 1'b1) taken_cycles++;
            if (dut.Reg[2] !== last_r2) begin
                r2_hist.push_back(dut.Reg[2]);
                last_r2 = dut.Reg[2];
            end
        end
        check32({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic freeze_and_compare(input string tag);
        logic [31:0] pc0;
        pc0 = dut.PC;
        repeat (6) @(negedge clk);
        check32({tag, "_pc_frozen"}, dut.PC, pc0);
        check32({tag, "_still_halted"}, 32'(halted), 32'd1);
        for (int i = 0; i < 32; i++)
            check32($sformatf("%s_reg%0d", tag, i), dut.Reg[i], m_reg[i]);
        for (int i = 0; i < 1024; i++)
            check32($sformatf("%s_mem%0d", tag, i), dut.Mem[i], m_mem[i]);
    endtask

    task automatic load_factorial();
        init_state(1'b0);
        for (int i = 0; i < 11; i++) put(i, FACT[i]);
        put(200, 32'd7);
    endtask

    task automatic gen_random(input int n);
        int i, kind, maxoff;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  op;
        i = 0;
        while (i < n) begin
            kind = int'($urandom_range(0, 9));
            rs   = 5'($urandom_range(0, 15));
            rt   = 5'($urandom_range(0, 15));
            rd   = 5'($urandom_range(0, 15));
            if (kind <= 3) begin
                op = 6'($urandom_range(0, 5));
                put(i, {op, rs, rt, rd, 11'd0});
            end else if (kind <= 5) begin
                op = 6'($urandom_range(10, 12));
                put(i, {op, rs, rt, 16'($urandom)});
            end else if (kind == 6 && i < n - 1) begin
                put(i, {OP_LW, 5'd0, rt, 16'(512 + $urandom_range(0, 63))});
                i++;
                put(i, NOP_W);
            end else if (kind == 7) begin
                put(i, {OP_SW, 5'd0, rt, 16'(512 + $urandom_range(0, 63))});
            end else if (kind == 8) begin
                maxoff = n - 1 - i;
                if (maxoff > 3) maxoff = 3;
                op = ($urandom_range(0, 1) == 0) ? OP_BEQZ : OP_BNEQZ;
                put(i, {op, rs, 5'd0, 16'($urandom_range(0, maxoff))});
            end else begin
                put(i, {6'($urandom_range(16, 62)), 26'($urandom)});
            end
            i++;
        end
        put(n, HLT_W);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;

        // Reset state.
        init_state(1'b0);
        repeat (2) @(negedge clk);
        check32("reset_pc", dut.PC, 32'd0);
        check32("reset_halted", 32'(halted), 32'd0);
        check32("reset_taken", 32'(dut.TAKEN_BRANCH), 32'd0);

        // Factorial of 7.
        load_factorial();
        model_run();
        do_reset();
        run_to_halt("fact", 60);
        check32("fact_mem198", dut.Mem[198], 32'd5040);
        check32("fact_reg2", dut.Reg[2], 32'd5040);
        check32("fact_mem200", dut.Mem[200], 32'd7);
        check32("fact_taken_cycles", 32'(taken_cycles), 32'd6);
        check32("fact_r2_len", 32'(r2_hist.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check32($sformatf("fact_r2_seq%0d", i),
                    (i < r2_hist.size()) ? r2_hist[i] : 32'hxxxxxxxx, R2_SEQ[i]);
        freeze_and_compare("fact");

        // Back-to-back forwarding.
        init_state(1'b0);
        put(0, {OP_ADDI, 5'd0, 5'd1, 16'd10});
        put(1, {OP_ADDI, 5'd0, 5'd2, 16'd20});
        put(2, {OP_ADDI, 5'd0, 5'd3, 16'd25});
        put(3, {6'd0, 5'd1, 5'd2, 5'd4, 11'd0});
        put(4, {6'd0, 5'd4, 5'd3, 5'd5, 11'd0});
        put(5, HLT_W);
        model_run();
        do_reset();
        run_to_halt("fwd", 100);
        check32("fwd_r4", dut.Reg[4], 32'd30);
        check32("fwd_r5", dut.Reg[5], 32'd55);
        freeze_and_compare("fwd");

        // Taken branch squashes the two following instructions.
        init_state(1'b0);
        put(0, {OP_BEQZ, 5'd0, 5'd0, 16'd2});
        put(1, {OP_ADDI, 5'd0, 5'd7, 16'd1});
        put(2, {OP_ADDI, 5'd0, 5'd8, 16'd1});
        put(3, {OP_ADDI, 5'd0, 5'd9, 16'd1});
        put(4, HLT_W);
        model_run();
        do_reset();
        run_to_halt("br", 100);
        check32("br_r7", dut.Reg[7], 32'd7);
        check32("br_r8", dut.Reg[8], 32'd8);
        check32("br_r9", dut.Reg[9], 32'd1);
        check32("br_taken_cycles", 32'(taken_cycles), 32'd1);
        freeze_and_compare("br");

        // HLT first, store right behind it must never land.
        init_state(1'b0);
        put(0, HLT_W);
        put(1, {OP_SW, 5'd0, 5'd1, 16'd0});
        model_run();
        do_reset();
        run_to_halt("hlt", 100);
        check32("hlt_latency", 32'(run_cycles), 32'd5);
        check32("hlt_mem0", dut.Mem[0], HLT_W);
        freeze_and_compare("hlt");

        // R0 discard and signed compares.
        init_state(1'b0);
        put(0, {OP_ADDI, 5'd0, 5'd0, 16'd5});
        put(1, {OP_SLTI, 5'd0, 5'd6, 16'hffff});
        put(2, {6'd1, 5'd0, 5'd1, 5'd11, 11'd0});
        put(3, HLT_W);
        model_run();
        do_reset();
        run_to_halt("r0", 100);
        check32("r0_reg0", dut.Reg[0], 32'd0);
        check32("r0_r6", dut.Reg[6], 32'd0);
        check32("r0_r11", dut.Reg[11], 32'hffffffff);
        freeze_and_compare("r0");

        // Reset in the middle of the factorial loop, then rerun.
        load_factorial();
        model_run();
        do_reset();
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check32("midrst_pc", dut.PC, 32'd0);
        check32("midrst_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        put(200, 32'd7);
        run_to_halt("midrst", 60);
        check32("midrst_mem198", dut.Mem[198], 32'd5040);
        check32("midrst_reg2", dut.Reg[2], 32'd5040);
        freeze_and_compare("midrst");

        // Random programs with random register/memory contents.
        for (int t = 0; t < 6; t++) begin
            init_state(1'b1);
            gen_random(24);
            model_run();
            do_reset();
            run_to_halt($sformatf("rnd%0d", t), 300);
            freeze_and_compare($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips32_pipeline.md
Name: mips32_pipeline

Overview:
- Five-stage in-order MIPS32-subset processor: IF, ID, EX, MEM, WB.
- Single unified 1024×32 word-addressed memory holds both instructions and data.
- Top-level compute core. Benches preload `Mem`/`Reg` hierarchically, release reset, and wait for `halted`.
- Full forwarding is provided; software still pads load/branch sequences with dummy instructions.

Parameters:
- MEM_DEPTH, 1024, words in unified memory; address = low log2(MEM_DEPTH) bits of the effective address or PC.
- NREGS, 32, general registers.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `halted` output 1: mirrors internal `HALTED`.

Behaviour:
- Hierarchically visible state:
  - `Reg[0:31]`, 32-bit.
  - `Mem[0:MEM_DEPTH-1]`, 32-bit.
  - `PC`, 32-bit.
  - `HALTED`.
  - `TAKEN_BRANCH`.
- Reset (`rst`=1 at edge):
  - `PC`=0, `HALTED`=0, `TAKEN_BRANCH`=0.
  - All pipeline registers are invalidated to bubbles.
  - `Reg` and `Mem` are NOT reset, so preloads survive.
  - Reset asserted mid-program aborts all in-flight instructions with no further writes.
- Fields:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
  - imm is sign-extended to 32 bits.
- RR ops, rd ← rs op rt:
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed compare, result 1/0.
  - MUL 000101: low 32 bits of the product.
- RM ops, rt ← rs op imm: ADDI 001010, SUBI 001011, SLTI 001100 (signed).
- Memory ops:
  - LW 001000: rt ← Mem[rs+imm].
  - SW 001001: Mem[rs+imm] ← rt.
- Branches:
  - BNEQZ 001101: taken if rs≠0.
  - BEQZ 001110: taken if rs==0.
  - Target = (branch PC + 1) + imm.
- HLT 111111.
- Any other opcode behaves as a NOP.
- R0 reads as 0; writes to R0 are discarded.
- IF:
  - Fetch `Mem[PC]`; `PC`←`PC`+1.
  - One instruction issued per cycle while not halted.
- ID:
  - Read rs/rt.
  - A WB write in the same cycle is visible (write-before-read).
- EX:
  - ALU, effective address, and branch condition.
  - Operands forwarded from EX/MEM (ALU result) and MEM/WB (ALU result or load data), youngest first.
- Branch resolution in EX:
  - If taken, at that edge: `PC`←target, `TAKEN_BRANCH`←1 for one cycle, and the two younger instructions (IF/ID and the one being fetched) become bubbles.
  - Penalty is 2 cycles; a not-taken branch has no penalty.
- MEM:
  - LW reads; SW writes at the rising edge.
  - Bubbles never write.
- WB:
  - Register write at the rising edge for RR, RM and LW.
- HLT:
  - When HLT is in WB, `HALTED`←1 at that edge.
  - The same edge suppresses the MEM write of the younger instruction.
  - Afterwards `PC`, all pipeline registers, `Reg` and `Mem` are frozen until reset.
  - Instructions after HLT never update architectural state.
- Load-use with one instruction between producer and consumer is covered by MEM/WB forwarding.
- Back-to-back load-use (no gap) is unsupported: there is no interlock and the result is undefined.
- Arithmetic wraps modulo 2^32.
- Address and PC wrap modulo MEM_DEPTH.

Test Plan:
- Factorial:
  - Preload `Reg[k]`=k, `Mem[200]`=7.
  - Program:
    - 0: 280a00c8 (ADDI R10,R0,200)
    - 1: 28020001 (ADDI R2,R0,1)
    - 2: 0e94a000 (OR R20,R20,R20)
    - 3: 21430000 (LW R3,0(R10))
    - 4: 0e94a000 (OR R20,R20,R20)
    - 5: 14431000 (MUL R2,R2,R3)
    - 6: 2c630001 (SUBI R3,R3,1)
    - 7: 0e94a000 (OR R20,R20,R20)
    - 8: 3460fffc (BNEQZ R3,-4)
    - 9: 2542fffe (SW R2,-2(R10))
    - 10: fc000000 (HLT)
  - Required: `halted`=1 within 60 cycles; `Mem[198]`=5040, `Reg[2]`=5040, `Mem[200]`=7.
  - `Reg[2]` sequence: 1, 7, 42, 210, 840, 2520, 5040, 5040.
- Forwarding:
  - Program: ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; ADD R4,R1,R2 issued back-to-back; ADD R5,R4,R3; HLT.
  - Required: R4=30, R5=55.
- Branch squash:
  - Program: BEQZ R0,+2; ADDI R7,R0,1; ADDI R8,R0,1; ADDI R9,R0,1; HLT.
  - Required: R7 and R8 unchanged, R9=1, `TAKEN_BRANCH` high for exactly one cycle.
- Halt freeze:
  - Program: HLT; then SW R1,0(R0) at the next address.
  - Required: `Mem[0]` unchanged, `PC` constant after `halted`=1.
- Reset mid-run:
  - Assert `rst` for 1 cycle during the factorial loop.
  - Required: `PC`=0, `halted`=0 next cycle, and the program reruns to the same result when `Mem[200]` is restored.
- R0 / SLT:
  - Program: ADDI R0,R0,5; SLTI R6,R0,-1; SUB R11,R0,R1 with R1=1; HLT.
  - Required: R0 reads 0, R6=0, R11=FFFFFFFF.
